decoder_3to8_fifo: RTL and testbench

DECODER_3TO8_FIFO -- requirements
Module: decoder_3to8_fifo

---
 rtl/decoder_pkg.sv | 16 +
 rtl/code_fifo.sv | 64 ++++++
 rtl/decoder_3to8_fifo.sv | 78 +++++++
 tb/tb_decoder_3to8_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and widths for the 3-to-8 decoder with input buffering.
// No logic of its own; the decode helper is pure combinational.
// Not applicable: there are no handshakes in this package.
package decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    function automatic onehot_t decode_onehot(input code_t code);
        return onehot_t'(8'h01) << code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Circular buffer of DEPTH binary codes with read/write pointers and an occupancy count.
// Latency: a code written at edge N is visible on head_code right after edge N.
// Backpressure: none internally; the caller must gate push on not-full and pop on not-empty.
module code_fifo
    import decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  code_t                      wr_code,
    input  logic                       pop,
    output code_t                      head_code,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    code_t            mem_q [DEPTH];
    code_t            mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_code;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_code = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/decoder_3to8_fifo.sv
// Buffers 3-bit codes and presents the one-hot decode of the oldest one; optional pop accumulator (DECODER_ACCUM_EN).
// Latency: 1 cycle from accepted code to out_y when empty; FIFO order otherwise.
// Backpressure: in_ready drops when full or en=0; out_ready=0 holds the head word stable.
module decoder_3to8_fifo
    import decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [CODE_W-1:0]      in_code,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [ONEHOT_W-1:0]    out_y,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
`ifdef DECODER_ACCUM_EN
    ,
    input  logic                   accum_clr,
    output logic [ONEHOT_W-1:0]    accum_mask
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic             push;
    logic             pop;
    code_t            head_code;
    logic [CNT_W-1:0] fifo_count;

    // No pop-bypass: a full buffer refuses input even if the head leaves this cycle.
    assign in_ready  = en && (fifo_count < DEPTH_C);
    assign out_valid = en && (fifo_count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_y     = out_valid ? decode_onehot(head_code) : '0;
    assign count     = fifo_count;

    code_fifo #(
        .DEPTH (DEPTH)
    ) u_code_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .wr_code   (in_code),
        .pop       (pop),
        .head_code (head_code),
        .count     (fifo_count)
    );

`ifdef DECODER_ACCUM_EN
    onehot_t accum_mask_q, accum_mask_d;

    // Clear takes priority over a pop landing on the same edge.
    always_comb begin
        accum_mask_d = accum_mask_q;
        if (accum_clr) begin
            accum_mask_d = '0;
        end else if (pop) begin
            accum_mask_d = accum_mask_q | out_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_mask_q <= '0;
        end else begin
            accum_mask_q <= accum_mask_d;
        end
    end

    assign accum_mask = accum_mask_q;
`endif

endmodule

// File: tb/tb_decoder_3to8_fifo.sv
// Scoreboard bench for decoder_3to8_fifo: driver queues expected words, negedge monitor compares pops.
module tb_decoder_3to8_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic [2:0]       in_code;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_y;
    logic             out_ready;
    logic [CNT_W-1:0] count;
`ifdef DECODER_ACCUM_EN
    logic             accum_clr;
    logic [7:0]       accum_mask;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    decoder_3to8_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_y     (out_y),
        .out_ready (out_ready),
        .count     (count)
`ifdef DECODER_ACCUM_EN
        ,
        .accum_clr (accum_clr),
        .accum_mask(accum_mask)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a code for one edge and record the word it must eventually produce.
    task automatic push_code(input logic [2:0] code);
        logic [7:0] one;
        one      = 8'h01;
        in_valid = 1'b1;
        in_code  = code;
        exp_q.push_back(one << code);
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: any accepted output word must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no output", out_y);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_y !== e) begin
                    errors++;
                    $display("FAIL pop_word: got 0x%0h expected 0x%0h at %0t", out_y, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b1;
        in_code   = 3'd5;
        out_ready = 1'b0;
`ifdef DECODER_ACCUM_EN
        accum_clr = 1'b0;
`endif
        // Reset holds everything empty even with a valid input offered.
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y",     32'(out_y),     32'h00);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        push_code(3'd5);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_y",     32'(out_y),     32'h20);
        out_ready = 1'b1;
        step();
        check("after_first_count", 32'(count), 32'd0);

        // Back-to-back sweep with the consumer always ready.
        for (int c = 7; c >= 0; c--) begin
            in_valid = 1'b1;
            in_code  = 3'(c);
            exp_q.push_back(8'h01 << c);
            step();
            if (c < 7) check("sweep_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("sweep_drained", 32'(count), 32'd0);

        // Fill to DEPTH with the consumer stalled, then offer one more.
        out_ready = 1'b0;
        push_code(3'd3);
        push_code(3'd1);
        push_code(3'd6);
        push_code(3'd2);
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_y_hold",   32'(out_y),    32'h08);
        in_valid = 1'b1;
        in_code  = 3'd7;
        step();
        in_valid = 1'b0;
        check("full_reject_count", 32'(count), 32'd4);
        check("full_y_stable",     32'(out_y), 32'h08);
        out_ready = 1'b1;
        repeat (4) step();
        check("full_drained", 32'(count), 32'd0);

        // Enable low freezes both sides and hides the head word.
        out_ready = 1'b0;
        push_code(3'd4);
        push_code(3'd0);
        en = 1'b0;
        #1;
        check("en0_out_valid", 32'(out_valid), 32'd0);
        check("en0_in_ready",  32'(in_ready),  32'd0);
        check("en0_out_y",     32'(out_y),     32'h00);
        in_valid  = 1'b1;
        in_code   = 3'd3;
        out_ready = 1'b1;
        step();
        check("en0_count", 32'(count), 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        en        = 1'b1;
        #1;
        check("en1_head", 32'(out_y), 32'h10);
        out_ready = 1'b1;
        step();
        step();
        check("en_drained", 32'(count), 32'd0);

        // Simultaneous push and pop keep occupancy constant.
        out_ready = 1'b0;
        push_code(3'd2);
        push_code(3'd5);
        out_ready = 1'b1;
        push_code(3'd7);
        check("simul_count1", 32'(count), 32'd2);
        push_code(3'd3);
        check("simul_count2", 32'(count), 32'd2);
        check("simul_head",   32'(out_y), 32'h80);
        out_ready = 1'b0;
        // Reset mid-burst discards buffered words without a clock edge.
        rst_n = 1'b0;
        #1;
        check("arst_count",     32'(count),     32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_y",     32'(out_y),     32'h00);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();

`ifdef DECODER_ACCUM_EN
        check("accum_reset", 32'(accum_mask), 32'h00);
        push_code(3'd1);
        push_code(3'd6);
        out_ready = 1'b1;
        step();
        step();
        check("accum_or", 32'(accum_mask), 32'h42);
        out_ready = 1'b0;
        push_code(3'd0);
        out_ready = 1'b1;
        accum_clr = 1'b1;
        step();
        accum_clr = 1'b0;
        check("accum_clr_wins", 32'(accum_mask), 32'h00);
        check("accum_pop_done", 32'(count),      32'd0);
`endif

        // Post-reset traffic flows normally.
        out_ready = 1'b1;
        push_code(3'd1);
        step();
        check("post_reset_count", 32'(count), 32'd0);
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
